// File: rtl/issue_sched.sv
// Issue scheduler / CDB arbiter: one grant per cycle (div > mult > int/ls), reserving the result's CDB slot.
// Done is combinational from ready; ISSUE_SCHED_LRU_EN selects alternating int/ls tie-break instead of int > ls.
module issue_sched #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issueint_ready,
    input  logic       issuels_ready,
    input  logic       issuemult_ready,
    input  logic       issuediv_ready,
    output logic       issueint_done,
    output logic       issuels_done,
    output logic       issuemult_done,
    output logic       issuediv_done,
    output logic [1:0] cdb_sel,
    output logic       cdb_sel_valid,
    output logic       div_busy
);

    localparam logic [1:0] SEL_INT  = 2'd0;
    localparam logic [1:0] SEL_LS   = 2'd1;
    localparam logic [1:0] SEL_MULT = 2'd2;
    localparam logic [1:0] SEL_DIV  = 2'd3;

    logic [DIV_LAT-1:0]      rsv_q, rsv_d;
    logic [DIV_LAT-1:0][1:0] own_q, own_d;
    logic [3:0]              div_cnt_q, div_cnt_d;
    logic                    gnt_int, gnt_ls, gnt_mult, gnt_div;
    logic                    slot1_ok;
    logic                    int_pref;

`ifdef ISSUE_SCHED_LRU_EN
    // Set when int should win the next int/ls tie, i.e. ls was granted last.
    logic int_pref_q, int_pref_d;
    assign int_pref = int_pref_q;
`else
    assign int_pref = 1'b1;
`endif

    always_comb begin
        gnt_div  = issuediv_ready && (div_cnt_q == 4'd0);
        gnt_mult = !gnt_div && issuemult_ready && !rsv_q[MULT_LAT];
        slot1_ok = !gnt_div && !gnt_mult && !rsv_q[1];
        gnt_int  = slot1_ok && issueint_ready && (int_pref || !issuels_ready);
        gnt_ls   = slot1_ok && issuels_ready && !gnt_int;
    end

    assign issueint_done  = reset && gnt_int;
    assign issuels_done   = reset && gnt_ls;
    assign issuemult_done = reset && gnt_mult;
    assign issuediv_done  = reset && gnt_div;

    always_comb begin
        rsv_d = {1'b0, rsv_q[DIV_LAT-1:1]};
        own_d = {2'b00, own_q[DIV_LAT-1:1]};
        if (gnt_div) begin
            rsv_d[DIV_LAT-1] = 1'b1;
            own_d[DIV_LAT-1] = SEL_DIV;
        end else if (gnt_mult) begin
            rsv_d[MULT_LAT-1] = 1'b1;
            own_d[MULT_LAT-1] = SEL_MULT;
        end else if (gnt_int) begin
            rsv_d[0] = 1'b1;
            own_d[0] = SEL_INT;
        end else if (gnt_ls) begin
            rsv_d[0] = 1'b1;
            own_d[0] = SEL_LS;
        end
    end

    // Counter hits zero in the cycle the div result is on the CDB, so a new div can be granted then.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (gnt_div)
            div_cnt_d = 4'(DIV_LAT - 1);
        else if (div_cnt_q != 4'd0)
            div_cnt_d = div_cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsv_q     <= '0;
            own_q     <= '0;
            div_cnt_q <= 4'd0;
        end else begin
            rsv_q     <= rsv_d;
            own_q     <= own_d;
            div_cnt_q <= div_cnt_d;
        end
    end

`ifdef ISSUE_SCHED_LRU_EN
    always_comb begin
        int_pref_d = int_pref_q;
        if (gnt_int)
            int_pref_d = 1'b0;
        else if (gnt_ls)
            int_pref_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            int_pref_q <= 1'b1;
        else
            int_pref_q <= int_pref_d;
    end
`endif

    assign cdb_sel_valid = rsv_q[0];
    assign cdb_sel       = rsv_q[0] ? own_q[0] : SEL_INT;
    assign div_busy      = (div_cnt_q != 4'd0);

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: calendar-based reference model of CDB slot ownership and divider occupancy.
module tb_issue_sched;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ri = 1'b0, rl = 1'b0, rm = 1'b0, rd = 1'b0;
    logic       d_int, d_ls, d_mult, d_div;
    logic [1:0] cdb_sel;
    logic       cdb_sel_valid, div_busy;

    issue_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset),
        .issueint_ready(ri), .issuels_ready(rl), .issuemult_ready(rm), .issuediv_ready(rd),
        .issueint_done(d_int), .issuels_done(d_ls), .issuemult_done(d_mult), .issuediv_done(d_div),
        .cdb_sel(cdb_sel), .cdb_sel_valid(cdb_sel_valid), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: absolute CDB cycle -> expected owner code.
    int cal[int];
    int div_free = 0;
    bit int_pref = 1'b1;
    bit started = 1'b0;
    int total = 0, bad = 0;
    int n_int = 0, n_ls = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: the CDB must show exactly what the scoreboard booked for this cycle.
    always @(negedge clk) begin
        if (started) begin
            if (!reset || !cal.exists(cyc)) begin
                chk("cdb_valid_idle", int'(cdb_sel_valid), 0);
                chk("cdb_sel_idle", int'(cdb_sel), 0);
            end else begin
                chk("cdb_valid", int'(cdb_sel_valid), 1);
                chk("cdb_sel", int'(cdb_sel), cal[cyc]);
            end
        end
    end

    task automatic model_eval();
        bit e_div, e_mult, e_int, e_ls, slot1;
        e_div  = rd && (cyc >= div_free);
        e_mult = !e_div && rm && !cal.exists(cyc + MULT_LAT);
        slot1  = !e_div && !e_mult && !cal.exists(cyc + 1);
`ifdef ISSUE_SCHED_LRU_EN
        e_int  = slot1 && ri && (int_pref || !rl);
`else
        e_int  = slot1 && ri;
`endif
        e_ls   = slot1 && rl && !e_int;
        chk("done", int'({d_div, d_mult, d_ls, d_int}), int'({e_div, e_mult, e_ls, e_int}));
        chk("div_busy", int'(div_busy), int'(cyc < div_free));
        if (d_int) n_int++;
        if (d_ls)  n_ls++;
        if (e_div) begin
            cal[cyc + DIV_LAT] = 3;
            div_free = cyc + DIV_LAT;
        end
        if (e_mult) cal[cyc + MULT_LAT] = 2;
        if (e_int) begin cal[cyc + 1] = 0; int_pref = 1'b0; end
        if (e_ls)  begin cal[cyc + 1] = 1; int_pref = 1'b1; end
    endtask

    task automatic drive(input logic [3:0] r);
        {rd, rm, rl, ri} = r;
    endtask

    task automatic step(input logic [3:0] r);
        @(posedge clk); #1;
        drive(r);
        @(negedge clk);
        model_eval();
    endtask

    // Readies held at r through reset and the first cycle after release.
    task automatic do_reset(input logic [3:0] r);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(r);
        cal.delete();
        div_free = 0;
        int_pref = 1'b1;
        started = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_done", int'({d_div, d_mult, d_ls, d_int}), 0);
            chk("rst_div_busy", int'(div_busy), 0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        model_eval();
    endtask

    initial begin
        // Reset with everything ready: div wins the first cycle after release.
        do_reset(4'b1111);
        repeat (10) step(4'b1111);

        // Single int request.
        do_reset(4'b0000);
        step(4'b0001);
        repeat (3) step(4'b0000);

        // Mult at t0 then int from t0+3: int blocked once by the mult slot.
        do_reset(4'b0000);
        step(4'b0100);
        repeat (2) step(4'b0000);
        repeat (3) step(4'b0001);
        repeat (3) step(4'b0000);

        // Div held continuously: back-to-back divs 7 cycles apart.
        do_reset(4'b0000);
        repeat (20) step(4'b1000);
        repeat (8) step(4'b0000);

        // Div at t0, mult from t0+3 collides with the div slot once.
        do_reset(4'b0000);
        step(4'b1000);
        repeat (2) step(4'b0000);
        repeat (3) step(4'b0100);
        repeat (10) step(4'b0000);

        // Int and ls both ready: tie-break behaviour.
        do_reset(4'b0000);
        n_int = 0;
        n_ls  = 0;
        repeat (8) step(4'b0011);
`ifdef ISSUE_SCHED_LRU_EN
        chk("tie_int_count", n_int, 4);
        chk("tie_ls_count", n_ls, 4);
`else
        chk("tie_int_count", n_int, 8);
        chk("tie_ls_count", n_ls, 0);
`endif
        repeat (3) step(4'b0000);

        // Randomised traffic with occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            r[0] = ($urandom_range(0, 99) < 60);
            r[1] = ($urandom_range(0, 99) < 50);
            r[2] = ($urandom_range(0, 99) < 35);
            r[3] = ($urandom_range(0, 99) < 20);
            if (i % 700 == 350)
                do_reset(r);
            else
                step(r);
        end
        repeat (DIV_LAT + 2) step(4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
